// File: rtl/tank_controller.sv
// -----------------------------------------------------------------------------
// tank_controller
//
// Serial access controller for the mercury-delay-line store. It owns the
// free-running circulation bit counter. For each access it waits until the
// addressed word reaches the tank output, then moves the word serially:
//   - a read gates one tank onto the shared output bus (mob) and deserialises
//     it into rdata;
//   - a write gates the tank clear/input and serialises wdata onto mib.
//
// Parameters
//   N_TANKS     populated tanks (1..32), tank index = addr[9:5]
//   CIRC_LEN    bit times per circulation
//   SHORT_BITS  bits per short word (a long word is twice this)
//
// Ports
//   clk, rst              clock (one bit time per cycle), async active-high reset
//   req, we, long, addr   access request, direction, size, address
//   wdata                 write word, bit 0 transmitted first
//   ack, err, busy        completion pulse, reject pulse, not-idle flag
//   rdata                 last read word (short reads zero-extended)
//   bit_pos               circulation counter 0..CIRC_LEN-1
//   mib                   serial write data to all tanks
//   tn_in, tn_clr, tn_out per-tank input / clear / output gates
//   mob                   shared tank output bus
//
// Optional feature (macro TANK_CTRL_BOUNDS_CHECK_EN)
//   Defined:   out-of-range tank or odd long address is rejected (ack + err).
//   Undefined: err tied to 0, long addresses forced even, out-of-range tanks
//              run a normal timed access with no gate; such a read returns 0.
// -----------------------------------------------------------------------------
module tank_controller #(
    parameter int N_TANKS    = 32,
    parameter int CIRC_LEN   = 576,
    parameter int SHORT_BITS = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               we,
    input  logic               long,
    input  logic [9:0]         addr,
    input  logic [35:0]        wdata,
    output logic               ack,
    output logic               err,
    output logic               busy,
    output logic [35:0]        rdata,
    output logic [9:0]         bit_pos,
    output logic               mib,
    output logic [N_TANKS-1:0] tn_in,
    output logic [N_TANKS-1:0] tn_clr,
    output logic [N_TANKS-1:0] tn_out,
    input  logic               mob
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_XFER   = 3'd2,
        S_DONE   = 3'd3,
        S_REJECT = 3'd4
    } state_t;

    localparam logic [9:0] CIRC_LAST = 10'(CIRC_LEN - 1);

    state_t      state_r;
    state_t      state_next_s;
    logic        we_r;
    logic        long_r;
    logic [4:0]  tank_r;
    logic [4:0]  idx_r;
    logic [35:0] wdata_r;
    logic [5:0]  cnt_r;
    logic [35:0] shift_r;
    logic [35:0] shift_next_s;
    logic [9:0]  start_s;
    logic [9:0]  start_m1_s;
    logic        last_s;
    logic        tank_ok_s;
    logic        mob_eff_s;
    logic        reject_s;

    // Window geometry and per-access decode of the latched request.
    always_comb begin
        start_s    = 10'(idx_r) * 10'(SHORT_BITS);
        // The counter passes start-1 just before the window opens; for
        // start 0 that is the last bit of the previous circulation.
        start_m1_s = (start_s == 10'd0) ? CIRC_LAST : (start_s - 10'd1);
        last_s     = (cnt_r == (long_r ? 6'(2 * SHORT_BITS - 1) : 6'(SHORT_BITS - 1)));
        tank_ok_s  = (32'(tank_r) < 32'(N_TANKS));
        // An unpopulated tank has no gate, so it contributes nothing to mob.
        mob_eff_s  = tank_ok_s ? mob : 1'b0;
        shift_next_s = shift_r;
        shift_next_s[cnt_r] = mob_eff_s;
    end

    // Request screening applied at acceptance.
    always_comb begin
`ifdef TANK_CTRL_BOUNDS_CHECK_EN
        reject_s = (long && addr[0]) || (32'(addr[9:5]) >= 32'(N_TANKS));
`else
        reject_s = 1'b0;
`endif
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req) begin
                    state_next_s = reject_s ? S_REJECT : S_WAIT;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_WAIT: begin
                // A request accepted with bit_pos already at start misses
                // this pass and waits a full circulation.
                if (bit_pos == start_m1_s) begin
                    state_next_s = S_XFER;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_XFER: begin
                if (last_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_XFER;
                end
            end
            S_DONE:   state_next_s = S_IDLE;
            S_REJECT: state_next_s = S_IDLE;
            default:  state_next_s = S_IDLE;
        endcase
    end

    // Tank gates and serial write data, decoded directly from state so they
    // line up with the bit window and drop as soon as reset is asserted.
    always_comb begin
        tn_in  = '0;
        tn_clr = '0;
        tn_out = '0;
        mib    = 1'b0;
        if (state_r == S_XFER) begin
            for (int i = 0; i < N_TANKS; i++) begin
                if (tank_r == 5'(i)) begin
                    if (we_r) begin
                        tn_in[i]  = 1'b1;
                        tn_clr[i] = 1'b1;
                    end else begin
                        tn_out[i] = 1'b1;
                    end
                end else begin
                    tn_out[i] = tn_out[i];
                end
            end
            mib = we_r ? wdata_r[cnt_r] : 1'b0;
        end else begin
            mib = 1'b0;
        end
    end

    // Free-running circulation bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_pos <= 10'd0;
        end else if (bit_pos == CIRC_LAST) begin
            bit_pos <= 10'd0;
        end else begin
            bit_pos <= bit_pos + 10'd1;
        end
    end

    // State, request latch, bit counter, deserialiser and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            we_r    <= 1'b0;
            long_r  <= 1'b0;
            tank_r  <= 5'd0;
            idx_r   <= 5'd0;
            wdata_r <= 36'd0;
            cnt_r   <= 6'd0;
            shift_r <= 36'd0;
            rdata   <= 36'd0;
            ack     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ack     <= (state_next_s == S_DONE) || (state_next_s == S_REJECT);
`ifdef TANK_CTRL_BOUNDS_CHECK_EN
            err     <= (state_next_s == S_REJECT);
`else
            err     <= 1'b0;
`endif
            busy    <= (state_next_s != S_IDLE);
            if ((state_r == S_IDLE) && req) begin
                we_r    <= we;
                long_r  <= long;
                tank_r  <= addr[9:5];
                // Long words occupy an even/odd short-word pair.
                idx_r   <= long ? {addr[4:1], 1'b0} : addr[4:0];
                wdata_r <= wdata;
                cnt_r   <= 6'd0;
                shift_r <= 36'd0;
            end else if (state_r == S_XFER) begin
                cnt_r <= cnt_r + 6'd1;
                if (!we_r) begin
                    shift_r <= shift_next_s;
                    // The final bit is folded in on the same edge that
                    // publishes the word, so rdata is valid with ack.
                    if (last_s) begin
                        rdata <= shift_next_s;
                    end else begin
                        rdata <= rdata;
                    end
                end else begin
                    shift_r <= shift_r;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_tank_controller.sv
`timescale 1ns/1ps
module tb_tank_controller;

    localparam int CL = 576;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we, long;
    logic [9:0]  addr;
    logic [35:0] wdata;
    logic        ack, err, busy, mib, mob;
    logic [35:0] rdata;
    logic [9:0]  bit_pos;
    logic [31:0] tn_in, tn_clr, tn_out;

    logic        req16, we16, long16;
    logic [9:0]  addr16;
    logic        ack16, err16, busy16, mib16;
    logic [35:0] rdata16;
    logic [9:0]  bit_pos16;
    logic [15:0] tn_in16, tn_clr16, tn_out16;

    tank_controller u_dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .long(long), .addr(addr),
        .wdata(wdata), .ack(ack), .err(err), .busy(busy), .rdata(rdata),
        .bit_pos(bit_pos), .mib(mib), .tn_in(tn_in), .tn_clr(tn_clr),
        .tn_out(tn_out), .mob(mob)
    );

    // Half-populated store; its bus is tied high so a wrongly gated read shows.
    tank_controller #(.N_TANKS(16)) u_dut16 (
        .clk(clk), .rst(rst), .req(req16), .we(we16), .long(long16), .addr(addr16),
        .wdata(36'd0), .ack(ack16), .err(err16), .busy(busy16), .rdata(rdata16),
        .bit_pos(bit_pos16), .mib(mib16), .tn_in(tn_in16), .tn_clr(tn_clr16),
        .tn_out(tn_out16), .mob(1'b1)
    );

    always #5 clk = ~clk;

    // Tank environment: physical store indexed by the bench's own circulation
    // count, plus a reference store updated from intended writes only.
    logic [CL-1:0] tmem [32];
    logic [CL-1:0] rmem [32];
    int tb_pos;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tb_pos <= 0;
        else     tb_pos <= (tb_pos == CL - 1) ? 0 : tb_pos + 1;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 32; i++) if (tn_in[i]) tmem[i][tb_pos] <= mib;
    end

    always_comb begin
        mob = 1'b0;
        for (int i = 0; i < 32; i++) if (tn_out[i]) mob = mob | tmem[i][tb_pos];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One access, checked every cycle against timing derived from the
    // circulation rules. pre_pos >= 0 aligns the accept cycle to that bit
    // position; abort_k >= 0 asserts reset while bit abort_k is transferred.
    task automatic access(input logic iwe, input logic ilong, input logic [9:0] iaddr,
                          input logic [35:0] iwd, input int pre_pos, input int abort_k,
                          output logic [35:0] got);
        int s, ln, w, p, tank, idx, last, k, guard;
        logic rej, inx, ea, ee, eb, em;
        logic [31:0] g, gi, go;
        logic [35:0] exp_rd;
        @(negedge clk);
        if (pre_pos >= 0) begin
            guard = 0;
            while (tb_pos != pre_pos && guard < 2 * CL) begin
                @(negedge clk);
                guard++;
            end
        end
        tank = int'(iaddr[9:5]);
        idx  = int'(iaddr[4:0]);
`ifdef TANK_CTRL_BOUNDS_CHECK_EN
        rej = ilong && iaddr[0];
`else
        rej = 1'b0;
        if (ilong) idx = idx - (idx % 2);
`endif
        s  = idx * 18;
        ln = ilong ? 36 : 18;
        p  = tb_pos;
        w  = (s - ((p + 1) % CL) + CL) % CL;
        if (w == 0) w = CL;
        exp_rd = 36'd0;
        for (int j = 0; j < ln; j++) exp_rd[j] = rmem[tank][s + j];
        req = 1'b1; we = iwe; long = ilong; addr = iaddr; wdata = iwd;
        @(negedge clk);
        req = 1'b0; we = ~iwe; long = ~ilong; addr = ~iaddr; wdata = ~iwd;
        last = rej ? 2 : w + ln + 2;
        for (int c = 1; c <= last; c++) begin
            if (rej) begin
                ea = (c == 1); ee = (c == 1); eb = (c == 1); em = 1'b0;
                gi = 32'd0; go = 32'd0;
            end else begin
                inx = (c > w) && (c <= w + ln);
                k   = inx ? c - w - 1 : 0;
                g   = inx ? (32'd1 << tank) : 32'd0;
                gi  = iwe ? g : 32'd0;
                go  = iwe ? 32'd0 : g;
                em  = (inx && iwe) ? iwd[k] : 1'b0;
                ea  = (c == w + ln + 1);
                ee  = 1'b0;
                eb  = (c <= w + ln + 1);
            end
            chk("outputs", {ack, err, busy, mib, tn_in, tn_clr, tn_out, bit_pos},
                {ea, ee, eb, em, gi, gi, go, 10'(tb_pos)});
            if (!rej && (c == w + ln + 1)) chk("ack_pos", 128'(bit_pos), 128'((s + ln) % CL));
            if (!rej && !iwe && c >= w + ln + 1) chk("rdata", 128'(rdata), 128'(exp_rd));
            if (abort_k >= 0 && !rej && c == w + abort_k + 1) begin
                rst = 1'b1;
                #1;
                chk("rst_abort", {busy, ack, err, mib, tn_in, tn_clr, tn_out, bit_pos}, 128'd0);
                @(negedge clk);
                rst = 1'b0;
                for (int j = 0; j < abort_k; j++) rmem[tank][s + j] = iwd[j];
                got = rdata;
                return;
            end
            @(negedge clk);
        end
        if (!rej && iwe) for (int j = 0; j < ln; j++) rmem[tank][s + j] = iwd[j];
        got = rdata;
    endtask

    typedef struct {
        logic        we;
        logic        lng;
        logic [9:0]  addr;
        logic [35:0] wd;
        int          pre;
        logic        chk_rd;
        logic [35:0] exp_rd;
    } vec_t;

    vec_t        vt [8];
    logic [35:0] got;
    int          c16;
    logic [9:0]  raddr;
    logic [35:0] rwd;

    initial begin
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < CL; j++) begin
                tmem[i][j] = 1'($urandom_range(0, 1));
                rmem[i][j] = tmem[i][j];
            end
        req = 1'b0; we = 1'b0; long = 1'b0; addr = 10'd0; wdata = 36'd0;
        req16 = 1'b0; we16 = 1'b0; long16 = 1'b0; addr16 = 10'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", {ack, err, busy, mib, tn_in, tn_clr, tn_out, bit_pos, rdata}, 128'd0);
        chk("reset_state16", {ack16, err16, busy16, tn_out16, bit_pos16, rdata16}, 128'd0);
        rst = 1'b0;

        //           we    long  addr     wdata            pre  chk   expected read
        vt[0] = '{1'b1, 1'b0, 10'h065, 36'h0_0002_AAAA, -1,  1'b0, 36'd0};
        vt[1] = '{1'b0, 1'b0, 10'h065, 36'd0,           -1,  1'b1, 36'h0_0002_AAAA};
        vt[2] = '{1'b1, 1'b1, 10'h3FE, 36'hF_0F0F_0F0F, -1,  1'b0, 36'd0};
        vt[3] = '{1'b0, 1'b1, 10'h3FE, 36'd0,           -1,  1'b1, 36'hF_0F0F_0F0F};
        vt[4] = '{1'b1, 1'b0, 10'h01F, 36'h0_0003_FFFF, 557, 1'b0, 36'd0};
        vt[5] = '{1'b0, 1'b0, 10'h01F, 36'd0,           556, 1'b1, 36'h0_0003_FFFF};
        vt[6] = '{1'b1, 1'b1, 10'h020, 36'h1_2345_6789, 575, 1'b0, 36'd0};
        vt[7] = '{1'b0, 1'b1, 10'h020, 36'd0,           -1,  1'b1, 36'h1_2345_6789};
        for (int i = 0; i < 8; i++) begin
            access(vt[i].we, vt[i].lng, vt[i].addr, vt[i].wd, vt[i].pre, -1, got);
            if (vt[i].chk_rd) chk("table_read", 128'(got), 128'(vt[i].exp_rd));
        end

        // Odd long address: rejected with the check, otherwise treated as even.
        access(1'b0, 1'b1, 10'h021, 36'd0, -1, -1, got);
`ifndef TANK_CTRL_BOUNDS_CHECK_EN
        chk("odd_long_read", 128'(got), 128'(36'h1_2345_6789));
`endif

        // Reset during bit 10 of a long write, then a normal write/read.
        access(1'b1, 1'b1, 10'h044, 36'hA_5A5A_5A5A, -1, 10, got);
        access(1'b0, 1'b1, 10'h044, 36'd0, -1, -1, got);
        chk("partial_write_low", 128'(got[9:0]), 128'(10'h25A));
        access(1'b1, 1'b0, 10'h0A7, 36'h0_0001_2345, -1, -1, got);
        access(1'b0, 1'b0, 10'h0A7, 36'd0, -1, -1, got);
        chk("post_reset_read", 128'(got), 128'(36'h0_0001_2345));

        // Random traffic against the reference store.
        for (int r = 0; r < 24; r++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            raddr = 10'($urandom);
            rwd   = {4'($urandom), 32'($urandom)};
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), raddr, rwd, -1, -1, got);
        end

        // Unpopulated tank 20 on the 16-tank controller.
        @(negedge clk);
        req16 = 1'b1; addr16 = {5'd20, 5'd2};
        @(negedge clk);
        req16 = 1'b0;
        c16 = 1;
        while (!ack16 && c16 < 700) begin
            chk("n16_gates", {mib16, tn_in16, tn_clr16, tn_out16, busy16}, 128'd1);
            @(negedge clk);
            c16++;
        end
        chk("n16_ack_seen", 128'(ack16), 128'd1);
        chk("n16_gates_ack", {mib16, tn_in16, tn_clr16, tn_out16, busy16}, 128'd1);
`ifdef TANK_CTRL_BOUNDS_CHECK_EN
        chk("n16_reject_latency", 128'(c16), 128'd1);
        chk("n16_err", 128'(err16), 128'd1);
`else
        chk("n16_err", 128'(err16), 128'd0);
        chk("n16_rdata", 128'(rdata16), 128'd0);
        chk("n16_ack_pos", 128'(bit_pos16), 128'd54);
`endif
        @(negedge clk);
        chk("n16_idle", {ack16, err16, busy16}, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tank_controller.md
# tank_controller

Serial access controller for the mercury-delay-line store. It sits between the order-processing unit and the 32 tank instances, and owns the free-running circulation bit counter. For each access it waits for the addressed word to reach the tank output, then moves the word serially. A read gates the tank output and deserialises onto a parallel word; a write gates tank clear/input and serialises a parallel word onto the shared input bus.

## Interface
- N_TANKS, 32, tanks populated (1..32); tank index = addr[9:5]
- CIRC_LEN, 576, bit times per circulation (16 long words × 36)
- SHORT_BITS, 18, bits per short word; long word = 2×SHORT_BITS

- clk  in  1  system clock, one bit time per cycle
- rst  in  1  reset, asynchronous, active-high
- req  in  1  access request, sampled in IDLE
- we  in  1  1 = write, 0 = read; latched with req
- long  in  1  1 = 36-bit access, 0 = 18-bit access
- addr  in  10  [9:5] tank, [4:0] short-word index
- wdata  in  36  write word, bit 0 transmitted first; short writes use [17:0]
- ack  out  1  one-cycle completion pulse
- err  out  1  one-cycle reject pulse, coincident with ack
- busy  out  1  high in every state but IDLE
- rdata  out  36  read word; short reads zero [35:18]
- bit_pos  out  10  circulation counter, 0..CIRC_LEN-1
- mib  out  1  serial write data to all tanks
- tn_in  out  N_TANKS  per-tank input gate
- tn_clr  out  N_TANKS  per-tank clear gate
- tn_out  out  N_TANKS  per-tank output gate
- mob  in  1  shared tank output bus (wired from all tanks)

## Operation
- bit_pos increments every cycle and wraps CIRC_LEN-1 → 0. Convention: during the cycle with bit_pos = p, mob carries circulation bit p of the gated tank, and mib with tn_in high is stored as bit p.
- start = addr[4:0] × SHORT_BITS; len = long ? 36 : 18. A long access must have addr[0] = 0; the window never wraps (max start+len-1 = 575).
- States:
  - IDLE: when req = 1, latch we/long/addr/wdata → WAIT (or REJECT, see Configuration).
  - WAIT: → XFER on the edge where bit_pos goes start-1 → start (mod CIRC_LEN). If bit_pos already equals start in the first WAIT cycle, wait a full circulation.
  - XFER: lasts len cycles with bit_pos = start..start+len-1. Bit k is transferred while bit_pos = start+k.
    - Read: tn_out[tank] = 1; mob is shifted into rdata position k at the edge closing the cycle.
    - Write: tn_in[tank] = tn_clr[tank] = 1; mib = wdata[k].
    - After the last bit → DONE.
  - DONE: ack = 1 for one cycle; rdata is updated (read only) and held until the next read completes → IDLE.
  - REJECT: ack = err = 1 for one cycle; no tank gate asserted → IDLE.
- At most one tank gate is active at any time. All gates and mib are 0 outside XFER.
- req is ignored while busy; there is no queueing.

## Timing
- Reset values: bit_pos = 0, state IDLE, ack = err = busy = 0, rdata = 0, mib = 0, all tn_* = 0.
- Reset mid-access aborts the access immediately. Gates drop asynchronously and the partial write leaves the earlier bits written. Tank contents are not realigned; address mapping after reset is valid only if the store is reloaded.
- Latency from the accept edge to ack: (wait 1..CIRC_LEN cycles) + len + 1.
- Outputs are registered except mib and tn_*, which are decoded from the state and bit count, with no added delay to the bit window.

## Configuration
- TANK_CTRL_BOUNDS_CHECK_EN:
  - Defined: a request whose tank index ≥ N_TANKS, or long = 1 with addr[0] = 1, goes to REJECT. err pulses one cycle after acceptance.
  - Undefined: err is tied to 0. addr[0] is ignored for long accesses (forced even). An out-of-range tank runs a normal timed access with no gate asserted; a read returns 0.

## Test plan
- Write short, tank 3, index 5 (start 90), wdata 0x2AAAA → tn_in[3]/tn_clr[3] high exactly for bit_pos 90..107, mib follows wdata LSB first; ack at bit_pos 108.
- Read back the same word via a tank model → rdata = 0x0000_2AAAA; tn_out[3] high only for bit_pos 90..107.
- Long write/read, tank 31, index 30 (start 540), 0xF_0F0F_0F0F → window 540..575, no wrap; read returns the same value.
- Request accepted with bit_pos = start in the first WAIT cycle → transfer starts a full 576 cycles later.
- With the macro defined: long access at addr 0x021 → ack = err = 1 the cycle after accept, all tn_* remain 0. Also N_TANKS = 16 with tank 20 → same rejection.
- Assert rst at bit 10 of a long write → all gates 0 immediately, bit_pos = 0, busy = 0; the next request completes normally.
